// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared constants for the 16-bit RISC CPU. It holds the data
//               width, the register count and the ALU opcode encoding. The
//               execution unit and the control unit both import it.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int DATA_W = 16;
    localparam int REG_N  = 8;
    localparam int REG_AW = 3;

    localparam logic [3:0] ALU_PASS = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_CMP  = 4'd3;
    localparam logic [3:0] ALU_MOV  = 4'd4;
    localparam logic [3:0] ALU_SHL  = 4'd5;
    localparam logic [3:0] ALU_SHR  = 4'd6;
    localparam logic [3:0] ALU_INC  = 4'd7;
    localparam logic [3:0] ALU_DEC  = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] ALU_OR   = 4'd10;
    localparam logic [3:0] ALU_XOR  = 4'd11;
    localparam logic [3:0] ALU_NOT  = 4'd12;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/cpu_alu.sv
`default_nettype none
// ============================================================================
// Module      : cpu_alu
// Description : Purely combinational ALU for the execution unit.
//   R, S      in  16  operands
//   alu_op    in  4   operation (see cpu_pkg)
//   Y         out 16  result
//   n, z, c   out 1   candidate flag values
//   flag_upd  out 1   high when this operation updates N/Z/C
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_alu
    import cpu_pkg::*;
(
    input  logic [DATA_W-1:0] R,
    input  logic [DATA_W-1:0] S,
    input  logic [3:0]        alu_op,
    output logic [DATA_W-1:0] Y,
    output logic              n,
    output logic              z,
    output logic              c,
    output logic              flag_upd
);

    // Arithmetic runs in 17 bits. For subtraction, bit 16 of the result is
    // set exactly when the subtrahend exceeds the minuend, so it serves as
    // the borrow.
    logic [DATA_W:0] w_sum;

    always_comb begin
        Y        = S;
        c        = 1'b0;
        flag_upd = 1'b0;
        w_sum    = '0;
        case (alu_op)
            ALU_PASS: Y = R;
            ALU_ADD: begin
                w_sum    = {1'b0, R} + {1'b0, S};
                Y        = w_sum[DATA_W-1:0];
                c        = w_sum[DATA_W];
                flag_upd = 1'b1;
            end
            ALU_SUB, ALU_CMP: begin
                w_sum    = {1'b0, R} - {1'b0, S};
                Y        = w_sum[DATA_W-1:0];
                c        = w_sum[DATA_W];
                flag_upd = 1'b1;
            end
            ALU_MOV: Y = S;
            ALU_SHL: begin
                Y        = {R[DATA_W-2:0], 1'b0};
                c        = R[DATA_W-1];
                flag_upd = 1'b1;
            end
            ALU_SHR: begin
                Y        = {1'b0, R[DATA_W-1:1]};
                c        = R[0];
                flag_upd = 1'b1;
            end
            ALU_INC: begin
                w_sum    = {1'b0, R} + 17'd1;
                Y        = w_sum[DATA_W-1:0];
                c        = w_sum[DATA_W];
                flag_upd = 1'b1;
            end
            ALU_DEC: begin
                w_sum    = {1'b0, R} - 17'd1;
                Y        = w_sum[DATA_W-1:0];
                c        = w_sum[DATA_W];
                flag_upd = 1'b1;
            end
            ALU_AND: begin Y = R & S; flag_upd = 1'b1; end
            ALU_OR:  begin Y = R | S; flag_upd = 1'b1; end
            ALU_XOR: begin Y = R ^ S; flag_upd = 1'b1; end
            ALU_NOT: begin Y = ~R;    flag_upd = 1'b1; end
            default: Y = S;
        endcase
    end

    assign n = Y[DATA_W-1];
    assign z = (Y == '0);

endmodule : cpu_alu
`default_nettype wire

// File: rtl/cpu_eu.sv
`default_nettype none
// ============================================================================
// Module      : cpu_eu
// Description : Execution unit of the 16-bit RISC CPU. Each clock it applies
//               the control word to an 8x16 register file, the ALU, the PC
//               and the IR, and returns IR plus N/Z/C to the control unit.
//   clk, reset           system clock; asynchronous active-low reset
//   W_Adr/R_Adr/S_Adr    register write / R-read / S-read addresses
//   adr_sel              memory address: 0 = PC, 1 = reg[R_Adr]
//   s_sel                S operand: 0 = reg[S_Adr], 1 = mem_rdata
//   pc_ld/pc_inc/pc_sel  PC load, increment, load-source select
//   ir_ld                IR <- mem_rdata
//   mw_en/rw_en          memory write / register-file write enables
//   alu_op               ALU operation
//   mem_rdata            asynchronous memory read data
//   mem_addr/mem_wdata/mem_we  memory port
//   IR, N, Z, C          instruction register and status flags
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_eu
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] W_Adr,
    input  logic [REG_AW-1:0] R_Adr,
    input  logic [REG_AW-1:0] S_Adr,
    input  logic              adr_sel,
    input  logic              s_sel,
    input  logic              pc_ld,
    input  logic              pc_inc,
    input  logic              pc_sel,
    input  logic              ir_ld,
    input  logic              mw_en,
    input  logic              rw_en,
    input  logic [3:0]        alu_op,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic [DATA_W-1:0] IR,
    output logic              N,
    output logic              Z,
    output logic              C
);

    logic [DATA_W-1:0] r_regs [REG_N];
    logic [DATA_W-1:0] r_pc;
    logic [DATA_W-1:0] r_ir;
    logic              r_n, r_z, r_c;

    logic [DATA_W-1:0] w_r, w_s, w_y, w_pc_rel;
    logic              w_n, w_z, w_c, w_flag_upd;

    assign w_r = r_regs[R_Adr];
    assign w_s = s_sel ? mem_rdata : r_regs[S_Adr];

    cpu_alu u_alu (
        .R        (w_r),
        .S        (w_s),
        .alu_op   (alu_op),
        .Y        (w_y),
        .n        (w_n),
        .z        (w_z),
        .c        (w_c),
        .flag_upd (w_flag_upd)
    );

    // Relative target: IR[7:0] sign-extended, wrapping mod 2^16.
    assign w_pc_rel = r_pc + {{(DATA_W-8){r_ir[7]}}, r_ir[7:0]};

    assign mem_addr  = adr_sel ? w_r : r_pc;
    assign mem_wdata = r_regs[S_Adr];
    assign mem_we    = mw_en;

    // Register file. Reads are combinational from the pre-edge contents.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < REG_N; i++) r_regs[i] <= '0;
        end else if (rw_en) begin
            r_regs[W_Adr] <= w_y;
        end
    end

    // The PC load samples w_r before the edge. A register written on the
    // same edge therefore contributes its old value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc <= '0;
        end else if (pc_ld) begin
            r_pc <= pc_sel ? w_r : w_pc_rel;
        end else if (pc_inc) begin
            r_pc <= r_pc + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ir <= '0;
        end else if (ir_ld) begin
            r_ir <= mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_n <= 1'b0;
            r_z <= 1'b0;
            r_c <= 1'b0;
        end else if (w_flag_upd) begin
            r_n <= w_n;
            r_z <= w_z;
            r_c <= w_c;
        end
    end

    assign IR = r_ir;
    assign N  = r_n;
    assign Z  = r_z;
    assign C  = r_c;

endmodule : cpu_eu
`default_nettype wire

// File: tb/tb_cpu_eu.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_eu
// Description : Self-checking bench for cpu_eu. The stimulus process applies
//               directed control words and queues the expected observations.
//               A monitor process drains the queue on every falling edge and
//               compares each entry against the DUT or the memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_eu;
    import cpu_pkg::*;

    localparam int K_ADDR  = 0;
    localparam int K_WDATA = 1;
    localparam int K_IR    = 2;
    localparam int K_FLAGS = 3;
    localparam int K_MEM   = 4;
    localparam int K_WE    = 5;

    typedef struct {
        string       name;
        int          kind;
        logic [15:0] exp;
        logic [15:0] addr;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  W_Adr, R_Adr, S_Adr;
    logic        adr_sel, s_sel, pc_ld, pc_inc, pc_sel, ir_ld, mw_en, rw_en;
    logic [3:0]  alu_op;
    logic [15:0] mem_rdata, mem_addr, mem_wdata, IR;
    logic        mem_we, N, Z, C;

    logic [15:0] mem [0:65535];
    logic        force_en;
    logic [15:0] force_val;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    // Memory model: asynchronous read, synchronous write. The bench can
    // override the read data to place values straight onto the S operand.
    assign mem_rdata = force_en ? force_val : mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

    cpu_eu dut (
        .clk       (clk),
        .reset     (reset),
        .W_Adr     (W_Adr),
        .R_Adr     (R_Adr),
        .S_Adr     (S_Adr),
        .adr_sel   (adr_sel),
        .s_sel     (s_sel),
        .pc_ld     (pc_ld),
        .pc_inc    (pc_inc),
        .pc_sel    (pc_sel),
        .ir_ld     (ir_ld),
        .mw_en     (mw_en),
        .rw_en     (rw_en),
        .alu_op    (alu_op),
        .mem_rdata (mem_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .IR        (IR),
        .N         (N),
        .Z         (Z),
        .C         (C)
    );

    // Monitor: compare every queued expectation at the falling edge.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t        e;
            logic [15:0] act;
            e = sb.pop_front();
            case (e.kind)
                K_ADDR:  act = mem_addr;
                K_WDATA: act = mem_wdata;
                K_IR:    act = IR;
                K_FLAGS: act = {13'b0, N, Z, C};
                K_MEM:   act = mem[e.addr];
                default: act = {15'b0, mem_we};
            endcase
            total++;
            if (act !== e.exp) begin
                bad++;
                $display("FAIL %s: actual=%h required=%h", e.name, act, e.exp);
            end
        end
    end

    task automatic push(input string n, input int k, input logic [15:0] e,
                        input logic [15:0] a = 16'h0);
        exp_t x;
        x.name = n; x.kind = k; x.exp = e; x.addr = a;
        sb.push_back(x);
    endtask

    task automatic idle();
        W_Adr = 3'd0; R_Adr = 3'd0; S_Adr = 3'd0;
        adr_sel = 1'b0; s_sel = 1'b0; pc_ld = 1'b0; pc_inc = 1'b0;
        pc_sel = 1'b0; ir_ld = 1'b0; mw_en = 1'b0; rw_en = 1'b0;
        alu_op = ALU_PASS; force_en = 1'b0; force_val = 16'h0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // reg[a] <- v through MOV with the read data overridden.
    task automatic load_reg(input logic [2:0] a, input logic [15:0] v);
        idle();
        W_Adr = a; s_sel = 1'b1; alu_op = ALU_MOV; rw_en = 1'b1;
        force_en = 1'b1; force_val = v;
        step();
        idle();
    endtask

    task automatic fetch();
        idle();
        ir_ld = 1'b1; pc_inc = 1'b1;
        step();
        idle();
    endtask

    initial begin
        idle();
        reset = 1'b0;
        mem[16'h0000] = 16'hE012;
        mem[16'h0100] = 16'h0000;
        @(negedge clk); #1 reset = 1'b1;

        // Build up non-reset state: PC=1, IR=E012, Z=C=1, reg1=8000.
        fetch();
        load_reg(3'd1, 16'h8000);
        R_Adr = 3'd1; W_Adr = 3'd2; alu_op = ALU_SHL; rw_en = 1'b1;
        step();
        idle(); S_Adr = 3'd1;
        push("pre_pc", K_ADDR, 16'h0001);
        push("pre_ir", K_IR, 16'hE012);
        push("pre_flags", K_FLAGS, 16'h0003);
        push("pre_reg1", K_WDATA, 16'h8000);
        step();

        // Reset mid-cycle takes effect without waiting for a clock edge.
        #2 reset = 1'b0;
        push("rst_pc", K_ADDR, 16'h0000);
        push("rst_reg1", K_WDATA, 16'h0000);
        push("rst_ir", K_IR, 16'h0000);
        push("rst_flags", K_FLAGS, 16'h0000);
        @(negedge clk); #1 reset = 1'b1;

        // FETCH on the first edge after release.
        fetch();
        push("fetch_ir", K_IR, 16'hE012);
        push("fetch_pc", K_ADDR, 16'h0001);
        step();

        // ADD with carry out.
        load_reg(3'd1, 16'hFFFF);
        load_reg(3'd2, 16'h0001);
        R_Adr = 3'd1; S_Adr = 3'd2; W_Adr = 3'd3; alu_op = ALU_ADD; rw_en = 1'b1;
        step();
        idle(); S_Adr = 3'd3;
        push("add_reg3", K_WDATA, 16'h0000);
        push("add_flags", K_FLAGS, 16'h0003);
        step();

        // CMP: flags only, then MOV of zero must not touch them.
        load_reg(3'd1, 16'h0005);
        load_reg(3'd2, 16'h0007);
        R_Adr = 3'd1; S_Adr = 3'd2; W_Adr = 3'd3; alu_op = ALU_CMP;
        step();
        idle(); S_Adr = 3'd3; adr_sel = 1'b1; R_Adr = 3'd1;
        push("cmp_flags", K_FLAGS, 16'h0005);
        push("cmp_reg3", K_WDATA, 16'h0000);
        push("cmp_reg1", K_ADDR, 16'h0005);
        step();
        load_reg(3'd4, 16'h0000);
        push("mov_flags", K_FLAGS, 16'h0005);
        step();

        // Store then load back through s_sel.
        load_reg(3'd4, 16'h0100);
        load_reg(3'd5, 16'hBEEF);
        adr_sel = 1'b1; R_Adr = 3'd4; S_Adr = 3'd5; mw_en = 1'b1;
        push("st_addr", K_ADDR, 16'h0100);
        push("st_wdata", K_WDATA, 16'hBEEF);
        push("st_we", K_WE, 16'h0001);
        step();
        idle();
        adr_sel = 1'b1; R_Adr = 3'd4; s_sel = 1'b1; alu_op = ALU_MOV;
        W_Adr = 3'd6; rw_en = 1'b1;
        push("st_mem", K_MEM, 16'hBEEF, 16'h0100);
        push("idle_we", K_WE, 16'h0000);
        step();
        idle(); S_Adr = 3'd6;
        push("ld_reg6", K_WDATA, 16'hBEEF);
        step();

        // Store and register write together: memory takes the old reg5.
        load_reg(3'd7, 16'h0200);
        adr_sel = 1'b1; R_Adr = 3'd7; S_Adr = 3'd5; W_Adr = 3'd5;
        mw_en = 1'b1; rw_en = 1'b1; alu_op = ALU_PASS;
        step();
        idle(); S_Adr = 3'd5;
        push("both_mem", K_MEM, 16'hBEEF, 16'h0200);
        push("both_reg5", K_WDATA, 16'h0200);
        step();

        // Relative branch backwards; pc_ld beats pc_inc.
        load_reg(3'd7, 16'h0010);
        R_Adr = 3'd7; pc_ld = 1'b1; pc_sel = 1'b1;
        step();
        idle(); ir_ld = 1'b1; force_en = 1'b1; force_val = 16'h00FE;
        step();
        idle(); pc_ld = 1'b1; pc_sel = 1'b0; pc_inc = 1'b1;
        step();
        idle();
        push("br_rel", K_ADDR, 16'h000E);
        step();

        // Absolute branch while the source register is rewritten.
        load_reg(3'd7, 16'h1234);
        R_Adr = 3'd7; pc_ld = 1'b1; pc_sel = 1'b1;
        W_Adr = 3'd7; rw_en = 1'b1; s_sel = 1'b1; alu_op = ALU_MOV;
        force_en = 1'b1; force_val = 16'h5555;
        step();
        idle(); S_Adr = 3'd7;
        push("br_abs", K_ADDR, 16'h1234);
        push("br_reg7", K_WDATA, 16'h5555);
        step();

        // PC wrap.
        load_reg(3'd7, 16'hFFFF);
        R_Adr = 3'd7; pc_ld = 1'b1; pc_sel = 1'b1;
        step();
        idle(); pc_inc = 1'b1;
        step();
        idle();
        push("pc_wrap", K_ADDR, 16'h0000);
        step();

        // SHR of 1 shifts the only set bit into C.
        load_reg(3'd1, 16'h0001);
        R_Adr = 3'd1; W_Adr = 3'd2; alu_op = ALU_SHR; rw_en = 1'b1;
        step();
        idle(); S_Adr = 3'd2;
        push("shr_reg2", K_WDATA, 16'h0000);
        push("shr_flags", K_FLAGS, 16'h0003);
        step();

        // Let the monitor drain; anything left over is a missed check.
        repeat (3) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: actual=%0d pending required=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_cpu_eu
`default_nettype wire

// File: doc/cpu_eu.md
# cpu_eu

Execution unit (datapath) of the 16-bit RISC CPU; the responder to the control unit's control word. Each clock it consumes the control word: register addresses, mux selects, PC/IR controls, write enables and ALU opcode. It executes that word against an 8×16 register file, ALU, PC and IR, and returns IR and the N/Z/C status flags to the control unit. Main memory is external, with an asynchronous read and a synchronous write.

## Interface
- No parameters; data width fixed at 16, register count fixed at 8.
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- W_Adr, R_Adr, S_Adr  in  3 each  register-file write / R-read / S-read addresses
- adr_sel  in  1  memory address select: 0 = PC, 1 = reg[R_Adr]
- s_sel  in  1  ALU S-operand select: 0 = reg[S_Adr], 1 = mem_rdata
- pc_ld, pc_inc, pc_sel, ir_ld  in  1 each  PC load, PC increment, PC source select, IR load
- mw_en, rw_en  in  1 each  memory write enable, register-file write enable
- alu_op  in  4  ALU operation
- mem_rdata  in  16  memory read data, combinational from mem_addr
- mem_addr  out  16  memory address
- mem_wdata  out  16  memory write data = reg[S_Adr]
- mem_we  out  1  = mw_en, combinational
- IR  out  16  instruction register
- N, Z, C  out  1 each  registered status flags

## Operation
- Operands:
  - R = reg[R_Adr].
  - S = s_sel ? mem_rdata : reg[S_Adr].
  - Y = ALU result, 16 bits; carry-out is c.
- alu_op encoding and flag effects:
  - 0 PASS_R (Y=R, flags hold)
  - 1 ADD (R+S, C=carry)
  - 2 SUB (R−S, C=borrow)
  - 3 CMP (as SUB; the control unit keeps rw_en=0)
  - 4 MOV (Y=S, flags hold)
  - 5 SHL (R<<1, C=R[15])
  - 6 SHR (logical R>>1, C=R[0])
  - 7 INC (R+1, C=carry)
  - 8 DEC (R−1, C=borrow)
  - 9 AND, 10 OR, 11 XOR, 12 NOT R: C=0
  - 13–15: Y=S, flags hold
- Flags update only for ops 1–3 and 5–12: N=Y[15], Z=(Y==0). All other ops hold N/Z/C.
- Register file: reg[W_Adr] ← Y on a clock edge when rw_en=1. All 8 registers are general purpose; reg 0 is not hard-wired.
- mem_addr = adr_sel ? reg[R_Adr] : PC.
- IR ← mem_rdata on a clock edge when ir_ld=1.
- PC, by priority:
  - pc_ld=1: PC ← pc_sel ? reg[R_Adr] : PC + sign_extend(IR[7:0]).
  - else pc_inc=1: PC ← PC+1.
  - else PC holds.
- Arithmetic is mod 2^16 throughout: PC 0xFFFF+1 = 0x0000, and relative jumps wrap.

## Timing
- Reset asserted (low): PC=0, IR=0, all registers=0, N=Z=C=0 immediately; mem_addr=0 when adr_sel=0.
- mem_addr, mem_wdata, mem_we and Y are combinational from the control word and current state. Zero-cycle latency to memory.
- Register-file, PC, IR and flag updates take effect on the edge ending the cycle. Reads in the same cycle see old values, so there is no write-to-read bypass.
- A FETCH word (adr_sel=0, ir_ld=1, pc_inc=1) loads IR ← mem[PC] and PC ← PC+1 on the same edge.
- If rw_en writes the register that is also the PC source on a pc_ld cycle, PC takes the old register value.
- pc_ld together with pc_inc: pc_ld wins and no increment occurs.
- mw_en together with rw_en: both occur. Memory receives the pre-edge reg[S_Adr].
- Reset asserted mid-operation overrides everything asynchronously. The first edge after release (high) executes the applied control word normally.

## Structure
- Shared package cpu_pkg holds the alu_op constants (ALU_PASS … ALU_NOT) and the data-width/register-count constants. The control unit uses the same package.
- Sub-module cpu_alu: purely combinational (R, S, alu_op → Y, n, z, c, flag_upd). cpu_eu owns the register file, PC, IR, flag registers and muxes.

## Test plan
- Reset and fetch:
  - Stimulus: assert reset low mid-run; then, with mem[0]=0xE012, apply a FETCH word.
  - Required: PC=0, IR=0, flags 0 immediately on reset. After the FETCH edge, IR=0xE012 and PC=1.
- ADD with carry:
  - Stimulus: reg1=0xFFFF, reg2=0x0001, R=1, S=2, W=3, alu_op=1, rw_en=1.
  - Required: reg3=0x0000, Z=1, C=1, N=0.
- CMP:
  - Stimulus: reg1=0x0005, reg2=0x0007, alu_op=3, rw_en=0.
  - Required: no register changes; N=1, C=1, Z=0. A following MOV leaves the flags unchanged.
- Store/load round trip:
  - Stimulus: mw_en=1, adr_sel=1, reg4=0x0100, reg5=0xBEEF.
  - Required: mem[0x0100]=0xBEEF. Then s_sel=1, alu_op=4, W=6, rw_en=1 gives reg6=0xBEEF.
- Branches:
  - Stimulus: PC=0x0010, IR[7:0]=0xFE, pc_ld=1, pc_sel=0, pc_inc=1.
  - Required: PC=0x000E. With pc_sel=1 and reg7=0x1234, PC=0x1234.
- Wrap:
  - Stimulus: PC=0xFFFF, pc_inc=1.
  - Required: PC=0x0000. SHR of 0x0001 gives Y=0, Z=1, C=1.
